b2_count_sequencer: RTL and testbench

Controller for an N-digit base-2 up-counter chain built from b2_up_counter cells. It takes a count request over a req/ack handshake, clears the counter, and drives its enable (ei) for exactly the requested number of cycles. It watches the counter's value and carry, then acknowledges completion. It sits between a requesting unit and the shared counter datapath, and is the only driver of the counter's enable and clear.

---
 rtl/b2_count_sequencer.sv | 102 ++++++++++
 tb/tb_b2_count_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/b2_count_sequencer.sv
// Sequencer for a base-2 up-counter chain: accepts a count request over req/ack,
// clears the chain, enables it for exactly `limit` cycles, and flags inconsistencies.
module b2_count_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic [N-1:0] limit,
  output logic         ack,
  output logic         busy,
  output logic         cnt_clr,
  output logic         cnt_ei,
  input  logic [N-1:0] cnt_q,
  input  logic         cnt_eu,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    COUNT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t       state, state_d;
  logic [N-1:0] lim_r, lim_d;
  logic         first_r, first_d;
  logic         ack_d, busy_d, err_d;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      lim_r   <= '0;
      first_r <= 1'b0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      lim_r   <= lim_d;
      first_r <= first_d;
      ack     <= ack_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

  // Next-state logic; cnt_clr/cnt_ei are decoded straight from state
  always_comb begin
    state_d = state;
    lim_d   = lim_r;
    first_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_ei  = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          lim_d   = limit;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        first_d = 1'b1;
        state_d = COUNT;
      end
      COUNT: begin
        cnt_ei = (cnt_q != lim_r);
        // Integrity faults take precedence over abort and completion
        if (first_r && (cnt_q != '0)) begin
          state_d = ERR;
        end else if (cnt_ei && cnt_eu) begin
          state_d = ERR;
        end else if (!req) begin
          state_d = IDLE;
        end else if (!cnt_ei) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
    err_d  = err || (state_d == ERR);
  end

endmodule

// File: tb/tb_b2_count_sequencer.sv
// Self-checking bench: behavioural counter chain plus a pulse/latency reference
// derived from the request limit.
module tb_b2_count_sequencer;

  localparam int unsigned N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req   = 1'b0;
  logic [N-1:0] limit = '0;
  logic         ack, busy, cnt_clr, cnt_ei, err;
  logic [N-1:0] cnt_q;
  logic         cnt_eu;

  logic [N-1:0] cnt_m     = '0;
  logic         force_en  = 1'b0;
  logic [N-1:0] force_val = '0;

  int n_assert = 0;
  int n_fail   = 0;

  b2_count_sequencer #(.N(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .limit   (limit),
    .ack     (ack),
    .busy    (busy),
    .cnt_clr (cnt_clr),
    .cnt_ei  (cnt_ei),
    .cnt_q   (cnt_q),
    .cnt_eu  (cnt_eu),
    .err     (err)
  );

  always #5 clock = ~clock;

  // Counter chain model: clear wins, else increment on enable
  always @(posedge clock) begin
    if (cnt_clr)     cnt_m <= '0;
    else if (cnt_ei) cnt_m <= cnt_m + 1'b1;
  end
  assign cnt_q  = force_en ? force_val : cnt_m;
  assign cnt_eu = cnt_ei & (&cnt_m);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"},  32'(ack),     32'd0);
    check({tag, "_busy"}, 32'(busy),    32'd0);
    check({tag, "_err"},  32'(err),     32'd0);
    check({tag, "_ei"},   32'(cnt_ei),  32'd0);
    check({tag, "_clr"},  32'(cnt_clr), 32'd0);
  endtask

  // One full request: enables must equal L, ack must rise L+2 edges after acceptance
  task automatic run_count(input logic [N-1:0] lim, input logic [N-1:0] mid_lim, input string tag);
    int pulses = 0;
    int clrs = 0;
    int n = 0;
    int overlap = 0;
    int eu_seen = 0;
    req   = 1'b1;
    limit = lim;
    step();
    while (!ack && n < 40) begin
      pulses += 32'(cnt_ei);
      clrs   += 32'(cnt_clr);
      if (cnt_ei && cnt_clr) overlap = 1;
      if (cnt_eu) eu_seen = 1;
      if (n == 2) limit = mid_lim;
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n),      32'(lim) + 32'd2);
    check({tag, "_pulses"},  32'(pulses), 32'(lim));
    check({tag, "_clrs"},    32'(clrs),   32'd1);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_eu"},      32'(eu_seen), 32'd0);
    check({tag, "_value"},   32'(cnt_q),  32'(lim));
    check({tag, "_busy"},    32'(busy),   32'd1);
    check({tag, "_err"},     32'(err),    32'd0);
    req = 1'b0;
    step();
    check({tag, "_ack_drop"},  32'(ack),  32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N-1:0] rl, rm;

    // Reset, then idle
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("idle");
    end

    // Directed counts, including both limit extremes
    run_count(4'd5,  4'd5,  "lim5");
    run_count(4'd0,  4'd0,  "lim0");
    run_count(4'd15, 4'd15, "lim15");

    // Limit changed mid-count must not affect completion
    run_count(4'd9, 4'd2, "limchg");

    // Randomized limits with random mid-count limit changes
    for (int i = 0; i < 6; i++) begin
      rl = N'($urandom_range(0, 15));
      rm = N'($urandom);
      run_count(rl, rm, "rand");
    end

    // Abort after three enable cycles
    req   = 1'b1;
    limit = 4'd10;
    step();
    step();
    step();
    step();
    req = 1'b0;
    step();
    check("abort_busy", 32'(busy),   32'd0);
    check("abort_ack",  32'(ack),    32'd0);
    check("abort_ei",   32'(cnt_ei), 32'd0);
    check("abort_cnt",  32'(cnt_q),  32'd3);
    step();
    check("abort_hold", 32'(cnt_q),  32'd3);
    run_count(4'd2, 4'd2, "after_abort");

    // Fault: counter fails to clear
    req   = 1'b1;
    limit = 4'd6;
    step();
    step();
    force_en  = 1'b1;
    force_val = 4'd3;
    step();
    force_en = 1'b0;
    check("fault_err",  32'(err),    32'd1);
    check("fault_busy", 32'(busy),   32'd1);
    check("fault_ei",   32'(cnt_ei), 32'd0);
    check("fault_ack",  32'(ack),    32'd0);
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    step();
    check("fault_sticky_err", 32'(err),     32'd1);
    check("fault_sticky_ack", 32'(ack),     32'd0);
    check("fault_sticky_clr", 32'(cnt_clr), 32'd0);
    check("fault_sticky_bsy", 32'(busy),    32'd1);
    req   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_quiet("fault_reset");

    // Reset mid-count
    req   = 1'b1;
    limit = 4'd8;
    step();
    for (int i = 0; i < 4; i++) step();
    check("midrst_counting", 32'(cnt_ei), 32'd1);
    reset = 1'b1;
    step();
    check_quiet("midrst");
    reset = 1'b0;
    req   = 1'b0;
    step();
    check_quiet("midrst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
